elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
- Parametrised, elastic register pipeline: DEPTH stages of WIDTH-bit data, each with its own valid bit, plus valid/ready handshake on both ends.
- Successor to the plain single-bit D flip-flop. Adds width, depth, reset data value, backpressure with bubble collapsing, synchronous flush and an occupancy count.
- Used wherever datapaths need retiming stages that can stall without losing or duplicating words.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_DATA, 0, value loaded into every stage data register on rst or flush (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of all stages, active-high
- in_valid  input  1  upstream word present
- in_data  input  WIDTH  upstream word
- in_ready  output  1  stage 0 can accept this cycle
- out_valid  output  1  valid bit of stage DEPTH-1
- out_data  output  WIDTH  data of stage DEPTH-1
- out_ready  input  1  downstream accepts
- count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates happen on the rising edge of clk.
- Reset: every valid bit is 0 and every data register is RESET_DATA. After reset: out_valid=0, out_data=RESET_DATA, count=0, in_ready=1.
- Per-stage advance condition:
  - adv[DEPTH-1] = !valid[DEPTH-1] | out_ready
  - adv[i] = !valid[i] | adv[i+1]
  - This is a combinational ready chain, so bubbles collapse.
- On an edge with adv[i]=1:
  - Stage i loads data and valid from stage i-1.
  - Stage 0 loads in_data, with valid = in_valid & in_ready.
  - Data registers load only when the incoming valid is 1. When the incoming valid is 0, only the valid bit clears and data holds (no toggling on bubbles).
- On an edge with adv[i]=0, stage i holds.
- in_ready = adv[0] & !flush. out_valid and out_data come directly from the registers of stage DEPTH-1 (no combinational path from in_* to out_*).
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Latency: a word transferred in at edge k sits in stage 0 after edge k. With no stalls it is presented on out_* during the cycle after edge k+DEPTH-1.
- Throughput: 1 word/cycle with out_ready held high.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- Full: all DEPTH valid bits set and out_ready=0 gives in_ready=0. With out_ready=1 while full, in_ready=1 and a simultaneous in/out transfer keeps count=DEPTH.
- count is combinational popcount of the valid bits, range 0..DEPTH.
- flush:
  - The next edge clears all valid bits and loads RESET_DATA into all data registers.
  - in_ready is forced to 0 during flush, so an in_valid word in the same cycle is not accepted.
  - out_valid may be 1 in the flush cycle. If out_ready=1 that output transfer counts as completed.
- rst has priority over flush. Both are identical in effect on state.
- rst mid-stream: all in-flight words are discarded. Next cycle out_valid=0 and count=0.
- DEPTH=1 is legal: a single-stage register slice with combinational in_ready from out_ready.

Decomposition:
- Shared package holds:
  - function clog2_plus1(depth), giving the count width
  - the default WIDTH/DEPTH constants used by integrators
- Natural sub-module: elastic_pipe_stage, which holds one stage's data and valid registers, its load/hold logic and RESET_DATA handling.
- The top generates DEPTH instances, chains adv, and computes count.

Test Plan (WIDTH=8, DEPTH=4, RESET_DATA=8'h00):
- Reset check: hold rst=1 for 2 cycles, release -> out_valid=0, out_data=8'h00, count=0, in_ready=1.
- Streaming: out_ready=1; push 8'h11, 8'h22, 8'h33 at edges 1, 2, 3 -> out_data=8'h11 in the cycle after edge 4, then 8'h22 and 8'h33 on consecutive cycles. Peak count=3, then returns to 0.
- Backpressure and full: out_ready=0; offer 8'h01..8'h06 continuously -> exactly 8'h01..8'h04 accepted, in_ready=0 after the 4th, count=4. Raise out_ready -> outputs 8'h01..8'h06 in order, none lost or duplicated.
- Bubble collapse: push 8'hA0 with out_ready=0; wait 6 cycles (word parked in stage 3, count=1); push 8'hA1, 8'hA2, 8'hA3 back-to-back -> all accepted with no stall, count=4, out_data=8'hA0 held stable throughout.
- Flush collision: with count=3, assert flush together with in_valid=1, in_data=8'h55 -> in_ready=0 that cycle. Next cycle count=0 and out_valid=0; 8'h55 never appears at the output.
- Reset mid-stream: with count=3, out_ready=0, pulse rst for 1 cycle -> next cycle count=0, out_valid=0, out_data=8'h00. Subsequent push of 8'h77 emerges with normal 4-stage latency.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
// elastic_pipe_reg_pkg: shared defaults and count-width helper for the elastic pipeline
package elastic_pipe_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2_plus1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: one data/valid register pair that loads on advance and holds otherwise
module elastic_pipe_stage
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // data only moves with a real word, so bubbles never toggle the data register
    always_comb begin
        valid_d = flush ? 1'b0 : adv ? in_valid : valid_q;
        data_d  = flush ? RESET_DATA : (adv && in_valid) ? in_data : data_q;
    end

    // stage state register, reset takes priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage elastic register pipeline with bubble-collapsing backpressure
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  out_data,
    input  logic                              out_ready,
    output logic [clog2_plus1(DEPTH)-1:0]     count
);

    localparam int CW = clog2_plus1(DEPTH);

    logic [DEPTH-1:0] valid, adv;
    logic [WIDTH-1:0] data [DEPTH];

    // ready chain from the output back: an empty stage or an advancing successor lets a stage move
    always_comb begin
        adv[DEPTH-1] = ~valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) adv[i] = ~valid[i] | adv[i+1];
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;
        if (g == 0) begin : g_head
            assign v_in = in_valid & in_ready;
            assign d_in = in_data;
        end else begin : g_body
            assign v_in = valid[g-1];
            assign d_in = data[g-1];
        end
        elastic_pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .adv      (adv[g]),
            .in_valid (v_in),
            .in_data  (d_in),
            .valid    (valid[g]),
            .data     (data[g])
        );
    end

    // occupancy is the popcount of the stage valid bits
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CW'(valid[i]);
    end

endmodule
